// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t    : controller states (IDLE, RUN, DONE)
//   DEF_MULT_WIDTH  : default operand width
package seq_mult_pkg;

  localparam int DEF_MULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_shift_add_mult_shift_add_step.sv
// One iteration of the shift-add multiply, purely combinational.
// Ports:
//   acc_i        : running partial product (2*WIDTH)
//   mcand_sh_i   : multiplicand shifted to the current bit weight (2*WIDTH)
//   mplier_sh_i  : remaining multiplier bits, LSB is the bit consumed now (WIDTH)
//   acc_o        : acc_i plus mcand_sh_i when the multiplier LSB is set
//   mcand_sh_o   : multiplicand advanced to the next bit weight
//   mplier_sh_o  : multiplier with the consumed bit dropped
module shift_add_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_sh_i,
  input  logic [WIDTH-1:0]   mplier_sh_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_sh_o,
  output logic [WIDTH-1:0]   mplier_sh_o
);

  // Wrap-around add: with WIDTH-bit unsigned operands the sum never exceeds 2*WIDTH bits.
  assign acc_o       = mplier_sh_i[0] ? (acc_i + mcand_sh_i) : acc_i;
  assign mcand_sh_o  = {mcand_sh_i[2*WIDTH-2:0], 1'b0};
  assign mplier_sh_o = {1'b0, mplier_sh_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH RUN
// cycles per product, valid/ready handshakes on both sides.
// Optional feature: define SEQ_MULT_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied and the sign is applied on completion).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and product stays stable until the consumer takes it with out_ready.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : operand pair valid       in_ready  : accepting (IDLE)
//   multiplier    : operand A                multiplicand : operand B
//   out_valid     : product valid (DONE)     out_ready : consumer accepts
//   product       : 2*WIDTH result, holds its value until the next completion
//   busy          : RUN or DONE
//   dbg_state     : current controller state (mult_state_t encoding)
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  mult_state_t       state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;

  logic [PW-1:0]     step_acc;
  logic [PW-1:0]     step_mcand;
  logic [WIDTH-1:0]  step_mplier;

  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [PW-1:0]     result;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i       (acc_q),
    .mcand_sh_i  (mcand_q),
    .mplier_sh_i (mplier_q),
    .acc_o       (step_acc),
    .mcand_sh_o  (step_mcand),
    .mplier_sh_o (step_mplier)
  );

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q, neg_d;

  // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign mag_a  = multiplier[WIDTH-1]   ? (~multiplier + WIDTH'(1))   : multiplier;
  assign mag_b  = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign result = neg_q ? (~step_acc + PW'(1)) : step_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end

  always_comb begin
    neg_d = neg_q;
    if (state_q == IDLE && in_valid)
      neg_d = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
  end
`else
  assign mag_a  = multiplier;
  assign mag_b  = multiplicand;
  assign result = step_acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_b};
          mplier_d = mag_a;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last iteration: publish the sum that includes this cycle's step.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = result;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  multiplier;
  logic [W-1:0]  multiplicand;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;
  logic [1:0]    dbg_state;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  int            acc_cyc_q[$];

  bit            b2b_mode = 1'b0;
  int            b2b_cnt = 0;
  int            last_acc = 0;

  bit            rdy_rand = 1'b0;
  bit            rdy_fixed = 1'b1;

  task automatic chk(input bit ok, input string name,
                     input logic [PW-1:0] act, input logic [PW-1:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: the arithmetic product of the operands, reduced to 2*W bits.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [PW-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return PW'(sa * sb);
`else
    logic [PW-1:0] ua, ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return PW'(ua * ub);
`endif
  endfunction

  // ---------------- recorder + monitor (negedge) ----------------
  logic          prev_ov = 1'b0;
  logic          prev_or = 1'b0;
  logic [PW-1:0] prev_prod = '0;
  logic [PW-1:0] last_prod = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov   = 1'b0;
      last_prod = '0;
      b2b_cnt   = 0;
    end else begin
      // Acceptance happens on the coming edge, whose index will be cyc+1.
      if (in_valid && in_ready) begin
        exp_q.push_back(model(multiplier, multiplicand));
        acc_cyc_q.push_back(cyc + 1);
        if (b2b_mode) begin
          if (b2b_cnt > 0)
            chk((cyc + 1 - last_acc) == W + 2, "accept_gap", PW'(cyc + 1 - last_acc), PW'(W + 2));
          b2b_cnt++;
        end else begin
          b2b_cnt = 0;
        end
        last_acc = cyc + 1;
      end

      chk(in_ready == !busy, "ready_vs_busy", PW'(in_ready), PW'(!busy));
      chk((dbg_state == 2'd0) == in_ready, "dbg_idle", PW'(dbg_state), PW'(!in_ready));
      if (out_valid) chk(busy, "valid_busy", PW'(busy), PW'(1));

      if (out_valid && !prev_ov) begin
        if (acc_cyc_q.size() == 0)
          chk(1'b0, "spurious_valid", PW'(out_valid), PW'(0));
        else
          chk(cyc == acc_cyc_q[0] + W, "latency", PW'(cyc - acc_cyc_q[0]), PW'(W));
      end

      if (prev_ov && !prev_or) begin
        chk(out_valid, "hold_valid", PW'(out_valid), PW'(1));
        chk(product == prev_prod, "hold_product", product, prev_prod);
      end

      if (!out_valid)
        chk(product == last_prod, "idle_product", product, last_prod);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_product", product, PW'(0));
        end else begin
          chk(product == exp_q[0], "product", product, exp_q[0]);
          void'(exp_q.pop_front());
          void'(acc_cyc_q.pop_front());
        end
        last_prod = product;
      end

      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_prod = product;
    end
  end

  // ---------------- out_ready driver ----------------
  initial out_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // ---------------- operand driver ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n;
    @(posedge clk); #1;
    multiplier   = a;
    multiplicand = b;
    in_valid     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    chk(in_ready, "accept_timeout", PW'(in_ready), PW'(1));
    @(posedge clk); #1;
    if (!hold) begin
      in_valid     = 1'b0;
      multiplier   = W'($urandom);
      multiplicand = W'($urandom);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 500);
    chk(out_valid, "valid_timeout", PW'(out_valid), PW'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain", PW'(exp_q.size()), PW'(0));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "reset_in_ready", PW'(in_ready), PW'(1));
    chk(out_valid == 1'b0, "reset_out_valid", PW'(out_valid), PW'(0));
    chk(busy == 1'b0, "reset_busy", PW'(busy), PW'(0));
    chk(product == '0, "reset_product", product, PW'(0));
    rst = 1'b0;

    // 3 x 5 with a ready consumer; IDLE again the cycle after the handshake.
    rdy_fixed = 1'b1;
    issue(W'(3), W'(5), 1'b0);
    wait_valid();
    @(negedge clk);
    chk(in_ready == 1'b1, "ready_after_done", PW'(in_ready), PW'(1));
    drain();

    // Boundary operands.
    issue('1, '1, 1'b0);
    drain();
    issue('0, W'(16'h1234), 1'b0);
    drain();
    issue(W'(16'h1234), '0, 1'b0);
    drain();
    issue(W'(16'hFFFD), W'(5), 1'b0);
    drain();
    issue(W'(16'h8000), W'(16'h8000), 1'b0);
    drain();
    issue(W'(16'h8000), W'(1), 1'b0);
    drain();

    // Backpressure: product held 10 cycles while in_valid pulses are ignored.
    rdy_fixed = 1'b0;
    issue(W'(16'h00FF), W'(16'h0100), 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid   = i[0];
      multiplier = W'($urandom);
    end
    in_valid  = 1'b0;
    rdy_fixed = 1'b1;
    drain();

    // Reset in the middle of RUN discards the operation.
    issue(W'(16'h1357), W'(16'h2468), 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk(in_ready == 1'b1, "midrst_in_ready", PW'(in_ready), PW'(1));
    chk(out_valid == 1'b0, "midrst_out_valid", PW'(out_valid), PW'(0));
    chk(busy == 1'b0, "midrst_busy", PW'(busy), PW'(0));
    chk(product == '0, "midrst_product", product, PW'(0));
    exp_q.delete();
    acc_cyc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(W'(2), W'(2), 1'b0);
    drain();

    // Back-to-back operands with in_valid held high.
    b2b_mode = 1'b1;
    for (int i = 0; i < 5; i++) issue(W'($urandom), W'($urandom), 1'b1);
    in_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;

    // Random operands with a randomly stalling consumer.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(pick_operand(), pick_operand(), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();
    rdy_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
